// File: rtl/ug_bist_pkg.sv
// Shared types and gate reference functions for the universal-gate BIST sequencer.
// The optional loop mode of ug_bist_seq is enabled by defining UG_BIST_LOOP_EN.
package ug_bist_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam int NUM_VECTORS = 4;

    function automatic logic exp_nand(input logic a, input logic b);
        return ~(a & b);
    endfunction

    function automatic logic exp_nor(input logic a, input logic b);
        return ~(a | b);
    endfunction

endpackage

// File: rtl/ug_bist_settle_cnt.sv
// Loadable down-counter that times the settle window for each vector.
// zero is high whenever the count has reached zero.
module ug_bist_settle_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign zero = (cnt == 4'd0);

endmodule

// File: rtl/ug_bist_seq.sv
// Exhaustive 2-input self-test of a NAND/NOR universal gate.
// Define UG_BIST_LOOP_EN for continuous looping and the err_count tally.
module ug_bist_seq
    import ug_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       gate_a,
    output logic       gate_b,
    input  logic       gate_nand,
    input  logic       gate_nor,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_vec
`ifdef UG_BIST_LOOP_EN
    ,
    input  logic       loop_en,
    output logic [7:0] err_count
`endif
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [1:0] LAST_IDX    = 2'(NUM_VECTORS - 1);

    state_t     state;
    logic [1:0] idx;
    logic       cnt_load;
    logic       cnt_zero;
    logic       mism;
    logic       loop_go;
    logic [3:0] fv_nxt;

`ifdef UG_BIST_LOOP_EN
    assign loop_go = loop_en;
`else
    assign loop_go = 1'b0;
`endif

    assign mism = (gate_nand != exp_nand(gate_a, gate_b))
                | (gate_nor  != exp_nor(gate_a, gate_b));
    assign fv_nxt = fail_vec | (4'(mism) << idx);

    // Reload the settle window whenever a new vector goes onto the gate.
    assign cnt_load = ((state == S_IDLE) && start && !abort)
                    | ((state == S_CHECK) && !abort && (idx != LAST_IDX))
                    | ((state == S_DONE) && loop_go);

    ug_bist_settle_cnt u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (SETTLE_LOAD),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= 2'd0;
            gate_a   <= 1'b0;
            gate_b   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail_vec <= 4'd0;
`ifdef UG_BIST_LOOP_EN
            err_count <= 8'd0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        idx      <= 2'd0;
                        gate_a   <= 1'b0;
                        gate_b   <= 1'b0;
                        fail_vec <= 4'd0;
                        pass     <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        state  <= S_IDLE;
                        busy   <= 1'b0;
                        gate_a <= 1'b0;
                        gate_b <= 1'b0;
                        pass   <= 1'b0;
                    end else if (cnt_zero) begin
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (abort) begin
                        state  <= S_IDLE;
                        busy   <= 1'b0;
                        gate_a <= 1'b0;
                        gate_b <= 1'b0;
                        pass   <= 1'b0;
                    end else begin
                        fail_vec <= fv_nxt;
`ifdef UG_BIST_LOOP_EN
                        if (mism && (err_count != 8'hFF))
                            err_count <= err_count + 8'd1;
`endif
                        if (idx == LAST_IDX) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (fv_nxt == 4'd0);
                        end else begin
                            idx              <= idx + 2'd1;
                            {gate_a, gate_b} <= idx + 2'd1;
                            state            <= S_SETTLE;
                        end
                    end
                end
                S_DONE: begin
                    if (loop_go) begin
                        idx      <= 2'd0;
                        gate_a   <= 1'b0;
                        gate_b   <= 1'b0;
                        fail_vec <= 4'd0;
                        pass     <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_SETTLE;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ug_bist_seq.sv
// Directed and randomized bench for ug_bist_seq in its default single-pass build.
// A fault-injecting gate model sits on the DUT's gate interface.
module tb_ug_bist_seq;

    localparam int S        = 2;
    localparam int PASS_LEN = 4 * (S + 1);

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       gate_a, gate_b;
    logic       gate_nand, gate_nor;
    logic       busy, done, pass;
    logic [3:0] fail_vec;
    logic [3:0] nand_flip = 4'd0;
    logic [3:0] nor_flip = 4'd0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Gate under test: correct response, optionally inverted per input vector.
    assign gate_nand = ~(gate_a & gate_b) ^ nand_flip[{gate_a, gate_b}];
    assign gate_nor  = ~(gate_a | gate_b) ^ nor_flip[{gate_a, gate_b}];

    ug_bist_seq #(.SETTLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .gate_a    (gate_a),
        .gate_b    (gate_b),
        .gate_nand (gate_nand),
        .gate_nor  (gate_nor),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_vec  (fail_vec)
    );

    function automatic logic [3:0] ref_fail(input logic [3:0] nf,
                                            input logic [3:0] rf);
        logic [3:0] f;
        f = 4'd0;
        for (int i = 0; i < 4; i++) begin
            int a, b, good_nand, good_nor, got_nand, got_nor;
            a = i / 2;
            b = i % 2;
            good_nand = (a * b == 0) ? 1 : 0;
            good_nor  = (a + b == 0) ? 1 : 0;
            got_nand  = nf[i] ? 1 - good_nand : good_nand;
            got_nor   = rf[i] ? 1 - good_nor : good_nor;
            f[i] = (got_nand != good_nand) || (got_nor != good_nor);
        end
        return f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_pass(input logic [3:0] nf, input logic [3:0] rf,
                            input string tag);
        logic [3:0] ef;
        nand_flip = nf;
        nor_flip  = rf;
        ef = ref_fail(nf, rf);
        @(negedge clk);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_v0"}, {busy, done, gate_a, gate_b}, 4'b1000);
        for (int c = 1; c < PASS_LEN; c++) begin
            tick();
            chk($sformatf("%s_c%0d", tag, c), {busy, done, gate_a, gate_b},
                {2'b10, 2'(c / (S + 1))});
        end
        tick();
        chk({tag, "_done"}, {busy, done}, 2'b01);
        chk({tag, "_fv"}, fail_vec, ef);
        chk({tag, "_pass"}, pass, (ef == 4'd0));
        tick();
        chk({tag, "_idle"}, {busy, done, pass, fail_vec},
            {1'b0, 1'b0, (ef == 4'd0), ef});
    endtask

    initial begin
        int ndone;
        logic [3:0] rn, rr;

        #2 rst_n = 1'b0;
        #1;
        chk("reset", {gate_a, gate_b, busy, done, pass, fail_vec}, 9'd0);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;

        run_pass(4'd0, 4'd0, "good");

        // NOR stuck-at-1 only shows where the correct NOR is 0.
        run_pass(4'd0, 4'b1110, "nor_sa1");
        chk("nor_sa1_fv_lit", {pass, fail_vec}, 5'b01110);

        for (int k = 0; k < 6; k++) begin
            rn = 4'($urandom);
            rr = 4'($urandom);
            run_pass(rn, rr, $sformatf("rnd%0d", k));
        end

        nand_flip = 4'd0;
        nor_flip  = 4'b1110;
        @(negedge clk);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 2 * (S + 1); c++) tick();
        chk("abort_pre_vec", {busy, gate_a, gate_b}, 3'b110);
        @(negedge clk);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", {busy, done, pass, gate_a, gate_b}, 5'd0);
        chk("abort_fv", fail_vec, ref_fail(4'd0, 4'b1110) & 4'b0011);
        ndone = 0;
        for (int c = 0; c < PASS_LEN + 2; c++) begin
            tick();
            if (done) ndone++;
        end
        chk("abort_nodone", ndone, 0);

        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("abort_pri%0d", c), {busy, done}, 2'b00);
        end
        start = 1'b0;
        abort = 1'b0;
        chk("idle_hold", {pass, fail_vec}, 5'b00010);

        nor_flip = 4'd0;
        @(negedge clk);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid", {gate_a, gate_b, busy, done, pass, fail_vec}, 9'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_pass(4'd0, 4'd0, "post_rst");

        @(negedge clk);
        start = 1'b1;
        tick();
        ndone = 0;
        for (int c = 1; c <= 2 * PASS_LEN + 2; c++) begin
            tick();
            if (done) ndone++;
            if (c == PASS_LEN)
                chk("held_done_t", done, 1'b1);
            if (c == PASS_LEN + 1)
                chk("held_gap", busy, 1'b0);
            if (c == PASS_LEN + 2)
                chk("held_restart", busy, 1'b1);
        end
        chk("held_ndone", ndone, 2);
        @(negedge clk);
        start = 1'b0;
        tick();
        tick();
        chk("held_end", {busy, done, pass}, 3'b001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
